// File: rtl/jesd204b_pkg.sv
// Shared definitions for the JESD204B link controller: state encodings and
// the multiframe beat-count derivation.
package jesd204b_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CGS  = 2'd1,
      ST_ILAS = 2'd2,
      ST_DATA = 2'd3
   } link_state_t;

   function automatic int beats_per_mf(input int octets_per_fr, input int frames_per_mf,
                                       input int octet_per_sent);
      return (octets_per_fr * frames_per_mf) / octet_per_sent;
   endfunction

   function automatic bit beats_exact(input int octets_per_fr, input int frames_per_mf,
                                      input int octet_per_sent);
      return ((octets_per_fr * frames_per_mf) % octet_per_sent) == 0;
   endfunction

endpackage

// File: rtl/jesd204b_sync_mon.sv
// SYNC~ low-run monitor: counts consecutive low cycles while the link is
// active and raises a one-cycle resync pulse when the run reaches the limit.
module jesd204b_sync_mon #(
   parameter int SYNC_ERR_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic sync_n,
   output logic resync
);

   localparam int CW = $clog2(SYNC_ERR_CYCLES + 1);
   localparam logic [CW-1:0] RUN_LAST = CW'(SYNC_ERR_CYCLES - 1);

   logic [CW-1:0] low_cnt;

   // Pulse on the cycle that completes the run, so the FSM leaves next edge.
   assign resync = active && !sync_n && (low_cnt == RUN_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         low_cnt <= '0;
      end else if (!active || sync_n || resync) begin
         low_cnt <= '0;
      end else begin
         low_cnt <= low_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/jesd204b_link_ctrl.sv
// JESD204B transmit link sequencer: IDLE -> CGS -> ILAS -> DATA with SYNC~
// driven resynchronisation and a saturating resync counter.
//
//  state | meaning
//  IDLE  | link disabled, all counters cleared
//  CGS   | code group sync, waiting for SYNC~ high at an LMFC edge
//  ILAS  | initial lane alignment, ILAS_MF multiframes
//  DATA  | user data; a long SYNC~ low run returns to CGS
module jesd204b_link_ctrl
   import jesd204b_pkg::*;
#(
   parameter int OCTETS_PER_FR   = 2,
   parameter int FRAMES_PER_MF   = 10,
   parameter int OCTET_PER_SENT  = 4,
   parameter int ILAS_MF         = 4,
   parameter int SYNC_ERR_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       sync_n,
   input  logic       lmfc_edge,
   output logic [1:0] state,
   output logic       cgs_en,
   output logic       ilas_en,
   output logic       data_en,
   output logic [1:0] mf_cnt,
   output logic [7:0] beat_cnt,
   output logic       ilas_r,
   output logic       ilas_a,
   output logic       ilas_q,
   output logic [7:0] resync_count
);

   localparam int BEATS_PER_MF = beats_per_mf(OCTETS_PER_FR, FRAMES_PER_MF, OCTET_PER_SENT);
   localparam logic [7:0] BEAT_LAST = 8'(BEATS_PER_MF - 1);
   localparam logic [1:0] MF_LAST   = 2'(ILAS_MF - 1);

   if (!beats_exact(OCTETS_PER_FR, FRAMES_PER_MF, OCTET_PER_SENT)) begin : g_bad_beats
      $error("octets per multiframe not a multiple of octets per beat");
   end
   if (ILAS_MF < 1 || ILAS_MF > 4) begin : g_bad_ilas
      $error("ILAS_MF must be in 1..4");
   end
   if (BEATS_PER_MF < 1 || BEATS_PER_MF > 256) begin : g_bad_range
      $error("beats per multiframe must be in 1..256");
   end
   if (SYNC_ERR_CYCLES < 1) begin : g_bad_sync
      $error("SYNC_ERR_CYCLES must be at least 1");
   end

   link_state_t cur_st, nxt_st;
   logic [1:0]  nxt_mf;
   logic [7:0]  nxt_beat;
   logic [7:0]  nxt_rc;
   logic        link_active;
   logic        resync;

   assign link_active = enable && ((cur_st == ST_ILAS) || (cur_st == ST_DATA));

   jesd204b_sync_mon #(
      .SYNC_ERR_CYCLES (SYNC_ERR_CYCLES)
   ) u_sync_mon (
      .clk    (clk),
      .reset  (reset),
      .active (link_active),
      .sync_n (sync_n),
      .resync (resync)
   );

   always_comb begin
      nxt_st   = cur_st;
      nxt_mf   = mf_cnt;
      nxt_beat = beat_cnt;
      nxt_rc   = resync_count;
      if (!enable) begin
         nxt_st = ST_IDLE;
      end else begin
         case (cur_st)
            ST_IDLE: nxt_st = ST_CGS;
            ST_CGS: begin
               if (lmfc_edge && sync_n) begin
                  nxt_st = ST_ILAS;
               end
            end
            ST_ILAS: begin
               // Resync wins over a coincident LMFC edge.
               if (resync) begin
                  nxt_st = ST_CGS;
               end else if (lmfc_edge) begin
                  if (mf_cnt == MF_LAST) begin
                     nxt_st = ST_DATA;
                  end else begin
                     nxt_mf   = mf_cnt + 2'd1;
                     nxt_beat = '0;
                  end
               end else if (beat_cnt != BEAT_LAST) begin
                  nxt_beat = beat_cnt + 8'd1;
               end
            end
            ST_DATA: begin
               if (resync) begin
                  nxt_st = ST_CGS;
               end
            end
            default: nxt_st = ST_IDLE;
         endcase
         if (resync && (resync_count != 8'hFF)) begin
            nxt_rc = resync_count + 8'd1;
         end
      end
      // Multiframe/beat indices only carry meaning inside ILAS.
      if (nxt_st != ST_ILAS) begin
         nxt_mf   = '0;
         nxt_beat = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_st       <= ST_IDLE;
         mf_cnt       <= '0;
         beat_cnt     <= '0;
         cgs_en       <= 1'b0;
         ilas_en      <= 1'b0;
         data_en      <= 1'b0;
         ilas_r       <= 1'b0;
         ilas_a       <= 1'b0;
         ilas_q       <= 1'b0;
         resync_count <= '0;
      end else begin
         cur_st       <= nxt_st;
         mf_cnt       <= nxt_mf;
         beat_cnt     <= nxt_beat;
         cgs_en       <= (nxt_st == ST_CGS);
         ilas_en      <= (nxt_st == ST_ILAS);
         data_en      <= (nxt_st == ST_DATA);
         ilas_r       <= (nxt_st == ST_ILAS) && (nxt_beat == 8'd0);
         ilas_a       <= (nxt_st == ST_ILAS) && (nxt_beat == BEAT_LAST);
         ilas_q       <= (nxt_st == ST_ILAS) && (nxt_mf == 2'd1) && (nxt_beat == 8'd0);
         resync_count <= nxt_rc;
      end
   end

   assign state = cur_st;

endmodule

// File: tb/tb_jesd204b_link_ctrl.sv
// Directed bench for jesd204b_link_ctrl with default parameters
// (5 beats per multiframe, 4 ILAS multiframes, resync after 4 low cycles).
module tb_jesd204b_link_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       sync_n;
   logic       lmfc_edge;
   logic [1:0] state;
   logic       cgs_en;
   logic       ilas_en;
   logic       data_en;
   logic [1:0] mf_cnt;
   logic [7:0] beat_cnt;
   logic       ilas_r;
   logic       ilas_a;
   logic       ilas_q;
   logic [7:0] resync_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jesd204b_link_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .sync_n       (sync_n),
      .lmfc_edge    (lmfc_edge),
      .state        (state),
      .cgs_en       (cgs_en),
      .ilas_en      (ilas_en),
      .data_en      (data_en),
      .mf_cnt       (mf_cnt),
      .beat_cnt     (beat_cnt),
      .ilas_r       (ilas_r),
      .ilas_a       (ilas_a),
      .ilas_q       (ilas_q),
      .resync_count (resync_count)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_st;
      int em;
      int eb;

      reset = 1'b1; enable = 1'b0; sync_n = 1'b0; lmfc_edge = 1'b0;
      step(); step(); step();

      // reset values
      chk("rst_state", state, 0);
      chk("rst_cgs_en", cgs_en, 0);
      chk("rst_ilas_en", ilas_en, 0);
      chk("rst_data_en", data_en, 0);
      chk("rst_mf", mf_cnt, 0);
      chk("rst_beat", beat_cnt, 0);
      chk("rst_marks", {ilas_r, ilas_a, ilas_q}, 0);
      chk("rst_rc", resync_count, 0);

      // sync_n held low: CGS forever from cycle 1
      reset = 1'b0; enable = 1'b1;
      for (int c = 0; c <= 100; c++) begin
         sync_n = 1'b0;
         lmfc_edge = (c > 0) && (c % 5 == 0);
         chk("cgs_hold_state", state, (c == 0) ? 8'd0 : 8'd1);
         step();
      end

      // fresh run: sync_n rises at 12, LMFC every 5 cycles
      reset = 1'b1; enable = 1'b0; lmfc_edge = 1'b0; sync_n = 1'b0;
      step(); step();
      reset = 1'b0; enable = 1'b1;
      for (int c = 0; c <= 40; c++) begin
         sync_n = (c >= 12);
         lmfc_edge = (c >= 5) && (c % 5 == 0);
         exp_st = (c == 0) ? 0 : (c < 16) ? 1 : (c < 36) ? 2 : 3;
         em = (exp_st == 2) ? (c - 16) / 5 : 0;
         eb = (exp_st == 2) ? (c - 16) % 5 : 0;
         chk("run_state", state, 8'(exp_st));
         chk("run_mf", mf_cnt, 8'(em));
         chk("run_beat", beat_cnt, 8'(eb));
         chk("run_ilas_r", ilas_r, (exp_st == 2 && eb == 0) ? 8'd1 : 8'd0);
         chk("run_ilas_a", ilas_a, (exp_st == 2 && eb == 4) ? 8'd1 : 8'd0);
         chk("run_ilas_q", ilas_q, (exp_st == 2 && em == 1 && eb == 0) ? 8'd1 : 8'd0);
         chk("run_ilas_en", ilas_en, (exp_st == 2) ? 8'd1 : 8'd0);
         chk("run_data_en", data_en, (exp_st == 3) ? 8'd1 : 8'd0);
         step();
      end
      lmfc_edge = 1'b0;

      // three-cycle low run in DATA: ignored
      sync_n = 1'b0;
      step(); step(); step();
      sync_n = 1'b1;
      chk("short_low_state", state, 3);
      step();
      chk("short_low_state2", state, 3);
      chk("short_low_rc", resync_count, 0);

      // four-cycle low run: back to CGS
      sync_n = 1'b0;
      step(); step(); step();
      chk("long_low_still_data", state, 3);
      step();
      chk("resync_state", state, 1);
      chk("resync_cgs_en", cgs_en, 1);
      chk("resync_data_en", data_en, 0);
      chk("resync_rc1", resync_count, 1);
      step(); step(); step();
      chk("cgs_low_rc_held", resync_count, 1);
      chk("cgs_low_state", state, 1);

      // back into ILAS, advance to multiframe 2, let beat saturate
      sync_n = 1'b1; lmfc_edge = 1'b1;
      step();
      chk("ilas2_entry_state", state, 2);
      chk("ilas2_entry_r", ilas_r, 1);
      step();
      chk("ilas2_mf1", mf_cnt, 1);
      chk("ilas2_q", ilas_q, 1);
      step();
      lmfc_edge = 1'b0;
      repeat (6) step();
      chk("sat_mf2", mf_cnt, 2);
      chk("sat_beat", beat_cnt, 4);
      chk("sat_ilas_a", ilas_a, 1);
      chk("sat_ilas_r", ilas_r, 0);

      // enable drop mid-ILAS
      enable = 1'b0;
      step();
      chk("dis_state", state, 0);
      chk("dis_mf", mf_cnt, 0);
      chk("dis_beat", beat_cnt, 0);
      chk("dis_ilas_en", ilas_en, 0);
      chk("dis_marks", {ilas_r, ilas_a, ilas_q}, 0);

      // re-enable, reach multiframe 3, then resync coinciding with LMFC
      enable = 1'b1;
      step();
      chk("reen_state", state, 1);
      sync_n = 1'b1; lmfc_edge = 1'b1;
      repeat (4) step();
      chk("pre_coinc_mf3", mf_cnt, 3);
      lmfc_edge = 1'b0; sync_n = 1'b0;
      step(); step(); step();
      lmfc_edge = 1'b1;
      step();
      lmfc_edge = 1'b0;
      chk("coinc_state", state, 1);
      chk("coinc_data_en", data_en, 0);
      chk("coinc_rc2", resync_count, 2);

      // reach DATA, then reset
      sync_n = 1'b1; lmfc_edge = 1'b1;
      repeat (5) step();
      lmfc_edge = 1'b0;
      chk("pre_reset_data", state, 3);
      reset = 1'b1;
      step();
      chk("mid_rst_state", state, 0);
      chk("mid_rst_ens", {cgs_en, ilas_en, data_en}, 0);
      chk("mid_rst_counts", {mf_cnt, beat_cnt[5:0]}, 0);
      chk("mid_rst_marks", {ilas_r, ilas_a, ilas_q}, 0);
      chk("mid_rst_rc", resync_count, 0);
      reset = 1'b0;
      step();
      chk("post_rst_cgs", state, 1);

      // 300 forced resyncs: counter saturates
      for (int i = 0; i < 300; i++) begin
         sync_n = 1'b1; lmfc_edge = 1'b1;
         step();
         sync_n = 1'b0; lmfc_edge = 1'b0;
         repeat (4) step();
         if (i == 99)  chk("rc_100", resync_count, 100);
         if (i == 253) chk("rc_254", resync_count, 254);
         if (i == 254) chk("rc_255", resync_count, 255);
      end
      chk("rc_sat", resync_count, 255);
      chk("rc_sat_state", state, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jesd204b_link_ctrl.md
JESD204B_LINK_CTRL -- requirements
Module: jesd204b_link_ctrl

Interface
REQ-001 The block SHALL have parameter OCTETS_PER_FR, default 2: octets per frame (F).
REQ-002 The block SHALL have parameter FRAMES_PER_MF, default 10: frames per multiframe (K).
REQ-003 The block SHALL have parameter OCTET_PER_SENT, default 4: octets per lane beat (one beat per clk).
REQ-004 The block SHALL have parameter ILAS_MF, default 4: number of ILAS multiframes.
REQ-005 The block SHALL have parameter SYNC_ERR_CYCLES, default 4: consecutive low sync_n cycles that trigger a resync.
REQ-006 The block SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 The block SHALL have port enable  input  1  link enable.
REQ-009 The block SHALL have port sync_n  input  1  receiver SYNC~ (low = sync request).
REQ-010 The block SHALL have port lmfc_edge  input  1  one-cycle pulse on the last beat of each local multiframe.
REQ-011 The block SHALL have port state  output  2  current state: IDLE=0, CGS=1, ILAS=2, DATA=3.
REQ-012 The block SHALL have ports cgs_en, ilas_en, data_en  output  1 each  one-hot state decodes.
REQ-013 The block SHALL have port mf_cnt  output  2  ILAS multiframe index.
REQ-014 The block SHALL have port beat_cnt  output  8  beat index within the multiframe.
REQ-015 The block SHALL have ports ilas_r, ilas_a, ilas_q  output  1 each  ILAS /R/, /A/ and config-start markers.
REQ-016 The block SHALL have port resync_count  output  8  saturating count of resyncs.

Function
REQ-017 BEATS_PER_MF SHALL equal OCTETS_PER_FR*FRAMES_PER_MF/OCTET_PER_SENT; elaboration SHALL fail if the division is inexact or if ILAS_MF>4.
REQ-018 All outputs SHALL be registered.
REQ-019 Priority SHALL be reset > enable low > state transitions.
REQ-020 enable low in any state SHALL force IDLE on the next cycle and clear mf_cnt and beat_cnt.
REQ-021 IDLE SHALL go to CGS on the cycle after enable is sampled high.
REQ-022 CGS SHALL go to ILAS on the cycle after an lmfc_edge sampled while sync_n=1; otherwise CGS SHALL be held.
REQ-023 On ILAS entry, mf_cnt=0 and beat_cnt=0.
REQ-024 In ILAS, beat_cnt SHALL clear to 0 on the cycle after each lmfc_edge, otherwise increment, saturating at BEATS_PER_MF-1.
REQ-025 In ILAS, mf_cnt SHALL increment on the cycle after each lmfc_edge.
REQ-026 An lmfc_edge with mf_cnt=ILAS_MF-1 SHALL move ILAS to DATA on the next cycle.
REQ-027 ilas_r=1 when ilas_en and beat_cnt=0; ilas_a=1 when ilas_en and beat_cnt=BEATS_PER_MF-1; ilas_q=1 when ilas_en, mf_cnt=1 and beat_cnt=0.
REQ-028 In ILAS or DATA, sync_n low for SYNC_ERR_CYCLES consecutive cycles SHALL move the state to CGS on the next cycle.
REQ-029 On that transition, the block SHALL increment resync_count (saturating at 255) and clear the low-run counter.
REQ-030 Shorter sync_n low runs SHALL have no effect.
REQ-031 In CGS and IDLE, the low-run counter SHALL be held at 0.
REQ-032 Simultaneous lmfc_edge and resync condition SHALL resolve to CGS.
REQ-033 Outside ILAS, mf_cnt, beat_cnt, ilas_r, ilas_a and ilas_q SHALL be 0.

Reset
REQ-034 reset SHALL set state=IDLE, all enables and markers=0, mf_cnt=0, beat_cnt=0, low-run counter=0 and resync_count=0.
REQ-035 Reset asserted mid-operation SHALL abort any ILAS/DATA on the next edge with no partial output.

Structure
REQ-036 The state encodings and the BEATS_PER_MF derivation SHALL live in a shared jesd204b_pkg package.
REQ-037 One sub-module, jesd204b_sync_mon, SHALL contain the sync_n low-run counter and emit a one-cycle resync pulse.

Verification
REQ-038 Scenario: reset, enable=1, sync_n=0 for 100 cycles, lmfc_edge every 5 cycles -> state=1 from cycle 1 onward, never 2.
REQ-039 Scenario: sync_n rises at cycle 12, lmfc_edge at 15,20,25,30,35 -> ILAS for cycles 16-35, DATA from 36, data_en=1.
REQ-040 Scenario: same run -> ilas_r at 16,21,26,31; ilas_a at 20,25,30,35; ilas_q only at 21; mf_cnt 0,1,2,3 per multiframe.
REQ-041 Scenario: in DATA, sync_n low 3 cycles -> stays DATA; sync_n low 4 cycles -> CGS next cycle, resync_count=1.
REQ-042 Scenario: enable low during ILAS (mf_cnt=2) -> IDLE next cycle, counters 0; reset during DATA -> all REQ-034 values.
REQ-043 Scenario: 300 forced resyncs -> resync_count holds 255.
